// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage pipelined datapath.
// Stage structs carry control and register indices only; XLEN-wide data lives beside them in the top.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

  typedef struct packed {
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       jump_alr;
    logic       alu_src;
    logic [3:0] alu_control;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [2:0] funct3;
    logic [4:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic [2:0] funct3;
    logic [4:0] rd;
  } mem_wb_t;

  // 32-bit sign-extended immediate; the datapath widens it to XLEN.
  function automatic logic [31:0] extend_imm(input logic [31:0] instr, input logic [1:0] src);
    case (src)
      IMM_I:   return {{20{instr[31]}}, instr[31:20]};
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Forwarding selects for the E-stage sources plus load-use stall and redirect flush.
module hazard_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic [1:0] result_src_e,
  input  logic       pc_src_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e
);

  function automatic fwd_t fwd_sel(input logic [4:0] rs, input logic [4:0] rdm, input logic rwm,
                                   input logic [4:0] rdw, input logic rww);
    if (rwm && rdm != 5'd0 && rs == rdm) return FWD_M;
    if (rww && rdw != 5'd0 && rs == rdw) return FWD_W;
    return FWD_RF;
  endfunction

  logic lw_stall;

  always_comb begin
    fwd_a_e  = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    fwd_b_e  = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
    lw_stall = (result_src_e == RESULT_MEM) && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    // A redirect always wins over holding F/D.
    stall_f  = lw_stall & ~pc_src_e;
    stall_d  = lw_stall & ~pc_src_e;
    flush_d  = pc_src_e;
    flush_e  = lw_stall | pc_src_e;
  end

endmodule

// File: rtl/pipelined_datapath.sv
// Five-stage F/D/E/M/W RV32I-style datapath with internal forwarding, load-use stall and redirect flush.
module pipelined_datapath
  import pipeline_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] PCF,
  input  logic [31:0]     InstrF,
  output logic [31:0]     InstrD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            JumpALRD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [1:0]      ImmSrcD,
  input  logic [3:0]      ALUControlD,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic            MemWriteM,
  output logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ReadDataM
);

  localparam int SHW  = $clog2(XLEN);
  localparam int OFFW = $clog2(XLEN / 8);

  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;
  logic [XLEN-1:0] pc_id_q, pc_id_d, pc4_id_q, pc4_id_d;
  id_ex_t          id_ex_q, id_ex_d;
  logic [XLEN-1:0] pc_ex_q, pc_ex_d, pc4_ex_q, pc4_ex_d;
  logic [XLEN-1:0] rd1_ex_q, rd1_ex_d, rd2_ex_q, rd2_ex_d, imm_ex_q, imm_ex_d;
  ex_mem_t         ex_mem_q, ex_mem_d;
  logic [XLEN-1:0] alu_mem_q, alu_mem_d, wd_mem_q, wd_mem_d, pc4_mem_q, pc4_mem_d;
  mem_wb_t         mem_wb_q, mem_wb_d;
  logic [XLEN-1:0] alu_wb_q, alu_wb_d, read_wb_q, read_wb_d, pc4_wb_q, pc4_wb_d;
  logic [XLEN-1:0] rf_q [32];

  logic [4:0]      rs1_d, rs2_d;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_d;
  logic [1:0]      fwd_a_e, fwd_b_e;
  logic            stall_f, stall_d, flush_d, flush_e;
  logic [XLEN-1:0] src_a_e, src_b_e, wd_e, alu_e, pc_target_e;
  logic [SHW-1:0]  shamt_e;
  logic            zero_e, lt_e, ltu_e, cond_e, pc_src_e;
  logic [XLEN-1:0] shifted_w, load_w, result_w;

  assign PCF        = pc_q;
  assign InstrD     = if_id_q.instr;
  assign ALUResultM = alu_mem_q;
  assign WriteDataM = wd_mem_q;
  assign MemWriteM  = ex_mem_q.mem_write;
  assign Funct3M    = ex_mem_q.funct3;
  assign rs1_d      = if_id_q.instr[19:15];
  assign rs2_d      = if_id_q.instr[24:20];

  hazard_unit u_hazard (
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (id_ex_q.rs1),
    .rs2_e        (id_ex_q.rs2),
    .rd_e         (id_ex_q.rd),
    .result_src_e (id_ex_q.result_src),
    .pc_src_e     (pc_src_e),
    .rd_m         (ex_mem_q.rd),
    .reg_write_m  (ex_mem_q.reg_write),
    .rd_w         (mem_wb_q.rd),
    .reg_write_w  (mem_wb_q.reg_write),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e)
  );

  // Register file reads see a same-cycle W write; x0 always reads zero.
  always_comb begin
    rd1_d = (rs1_d == 5'd0) ? '0 : rf_q[rs1_d];
    rd2_d = (rs2_d == 5'd0) ? '0 : rf_q[rs2_d];
    if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == rs1_d) rd1_d = result_w;
    if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == rs2_d) rd2_d = result_w;
    imm_d = XLEN'($signed(extend_imm(if_id_q.instr, ImmSrcD)));
  end

  always_comb begin
    case (fwd_a_e)
      FWD_M:   src_a_e = alu_mem_q;
      FWD_W:   src_a_e = result_w;
      default: src_a_e = rd1_ex_q;
    endcase
    case (fwd_b_e)
      FWD_M:   wd_e = alu_mem_q;
      FWD_W:   wd_e = result_w;
      default: wd_e = rd2_ex_q;
    endcase
    src_b_e = id_ex_q.alu_src ? imm_ex_q : wd_e;
    shamt_e = src_b_e[SHW-1:0];
    lt_e    = $signed(src_a_e) < $signed(src_b_e);
    ltu_e   = src_a_e < src_b_e;
    case (id_ex_q.alu_control)
      ALU_SUB:  alu_e = src_a_e - src_b_e;
      ALU_AND:  alu_e = src_a_e & src_b_e;
      ALU_OR:   alu_e = src_a_e | src_b_e;
      ALU_XOR:  alu_e = src_a_e ^ src_b_e;
      ALU_SLT:  alu_e = XLEN'(lt_e);
      ALU_SLTU: alu_e = XLEN'(ltu_e);
      ALU_SLL:  alu_e = src_a_e << shamt_e;
      ALU_SRL:  alu_e = src_a_e >> shamt_e;
      ALU_SRA:  alu_e = $signed(src_a_e) >>> shamt_e;
      default:  alu_e = src_a_e + src_b_e;
    endcase
    zero_e = (alu_e == '0);
    case (id_ex_q.funct3)
      3'b000:  cond_e = zero_e;
      3'b001:  cond_e = ~zero_e;
      3'b100:  cond_e = lt_e;
      3'b101:  cond_e = ~lt_e;
      3'b110:  cond_e = ltu_e;
      3'b111:  cond_e = ~ltu_e;
      default: cond_e = 1'b0;
    endcase
    pc_src_e    = id_ex_q.jump | (id_ex_q.branch & cond_e);
    // jalr targets drop bit 0 so odd base+offset still lands on an instruction.
    pc_target_e = id_ex_q.jump_alr ? (alu_e & ~XLEN'(1)) : (pc_ex_q + imm_ex_q);
  end

  always_comb begin
    shifted_w = read_wb_q >> {alu_wb_q[OFFW-1:0], 3'b000};
    case (mem_wb_q.funct3)
      3'b000:  load_w = XLEN'($signed(shifted_w[7:0]));
      3'b001:  load_w = XLEN'($signed(shifted_w[15:0]));
      3'b010:  load_w = XLEN'($signed(shifted_w[31:0]));
      3'b100:  load_w = XLEN'(shifted_w[7:0]);
      3'b101:  load_w = XLEN'(shifted_w[15:0]);
      3'b110:  load_w = XLEN'(shifted_w[31:0]);
      default: load_w = shifted_w;
    endcase
    case (mem_wb_q.result_src)
      RESULT_MEM: result_w = load_w;
      RESULT_PC4: result_w = pc4_wb_q;
      default:    result_w = alu_wb_q;
    endcase
  end

  always_comb begin
    if (pc_src_e)     pc_d = pc_target_e;
    else if (stall_f) pc_d = pc_q;
    else              pc_d = pc_q + XLEN'(4);

    if_id_d  = if_id_q;
    pc_id_d  = pc_id_q;
    pc4_id_d = pc4_id_q;
    if (flush_d) begin
      if_id_d.instr = NOP_INSTR;
      pc_id_d       = '0;
      pc4_id_d      = '0;
    end else if (!stall_d) begin
      if_id_d.instr = InstrF;
      pc_id_d       = pc_q;
      pc4_id_d      = pc_q + XLEN'(4);
    end

    id_ex_d  = '0;
    pc_ex_d  = '0;
    pc4_ex_d = '0;
    rd1_ex_d = '0;
    rd2_ex_d = '0;
    imm_ex_d = '0;
    if (!flush_e) begin
      id_ex_d.reg_write   = RegWriteD;
      id_ex_d.result_src  = ResultSrcD;
      id_ex_d.mem_write   = MemWriteD;
      id_ex_d.jump        = JumpD;
      id_ex_d.branch      = BranchD;
      id_ex_d.jump_alr    = JumpALRD;
      id_ex_d.alu_src     = ALUSrcD;
      id_ex_d.alu_control = ALUControlD;
      id_ex_d.funct3      = if_id_q.instr[14:12];
      id_ex_d.rs1         = rs1_d;
      id_ex_d.rs2         = rs2_d;
      id_ex_d.rd          = if_id_q.instr[11:7];
      pc_ex_d             = pc_id_q;
      pc4_ex_d            = pc4_id_q;
      rd1_ex_d            = rd1_d;
      rd2_ex_d            = rd2_d;
      imm_ex_d            = imm_d;
    end

    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.result_src = id_ex_q.result_src;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.funct3     = id_ex_q.funct3;
    ex_mem_d.rd         = id_ex_q.rd;
    alu_mem_d           = alu_e;
    wd_mem_d            = wd_e;
    pc4_mem_d           = pc4_ex_q;

    mem_wb_d.reg_write  = ex_mem_q.reg_write;
    mem_wb_d.result_src = ex_mem_q.result_src;
    mem_wb_d.funct3     = ex_mem_q.funct3;
    mem_wb_d.rd         = ex_mem_q.rd;
    alu_wb_d            = alu_mem_q;
    read_wb_d           = ReadDataM;
    pc4_wb_d            = pc4_mem_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_q.instr <= NOP_INSTR;
      pc_id_q       <= '0;
      pc4_id_q      <= '0;
      id_ex_q       <= '0;
      pc_ex_q       <= '0;
      pc4_ex_q      <= '0;
      rd1_ex_q      <= '0;
      rd2_ex_q      <= '0;
      imm_ex_q      <= '0;
      ex_mem_q      <= '0;
      alu_mem_q     <= '0;
      wd_mem_q      <= '0;
      pc4_mem_q     <= '0;
      mem_wb_q      <= '0;
      alu_wb_q      <= '0;
      read_wb_q     <= '0;
      pc4_wb_q      <= '0;
    end else begin
      pc_q      <= pc_d;
      if_id_q   <= if_id_d;
      pc_id_q   <= pc_id_d;
      pc4_id_q  <= pc4_id_d;
      id_ex_q   <= id_ex_d;
      pc_ex_q   <= pc_ex_d;
      pc4_ex_q  <= pc4_ex_d;
      rd1_ex_q  <= rd1_ex_d;
      rd2_ex_q  <= rd2_ex_d;
      imm_ex_q  <= imm_ex_d;
      ex_mem_q  <= ex_mem_d;
      alu_mem_q <= alu_mem_d;
      wd_mem_q  <= wd_mem_d;
      pc4_mem_q <= pc4_mem_d;
      mem_wb_q  <= mem_wb_d;
      alu_wb_q  <= alu_wb_d;
      read_wb_q <= read_wb_d;
      pc4_wb_q  <= pc4_wb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0) rf_q[mem_wb_q.rd] <= result_w;
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench: plays instruction memory, main decoder and a one-word data memory around the datapath.
module tb_pipelined_datapath;
  import pipeline_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] PCF, InstrF, InstrD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, JumpALRD, ALUSrcD;
  logic [1:0]  ResultSrcD, ImmSrcD;
  logic [3:0]  ALUControlD;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [0:127];
  logic [31:0] fetch_pc [0:63];
  int          st_cyc[$];
  logic [31:0] st_addr[$];
  logic [31:0] st_data[$];
  int          cyc;
  logic        running;

  pipelined_datapath #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCF         (PCF),
    .InstrF      (InstrF),
    .InstrD      (InstrD),
    .RegWriteD   (RegWriteD),
    .MemWriteD   (MemWriteD),
    .JumpD       (JumpD),
    .BranchD     (BranchD),
    .JumpALRD    (JumpALRD),
    .ALUSrcD     (ALUSrcD),
    .ResultSrcD  (ResultSrcD),
    .ImmSrcD     (ImmSrcD),
    .ALUControlD (ALUControlD),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .MemWriteM   (MemWriteM),
    .Funct3M     (Funct3M),
    .ReadDataM   (ReadDataM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign InstrF    = imem[PCF[8:2]];
  assign ReadDataM = (ALUResultM == 32'h0) ? 32'h7 : 32'h0;

  // Main decoder model for the small instruction subset the programs use.
  always_comb begin
    RegWriteD = 1'b0; MemWriteD = 1'b0; JumpD = 1'b0; BranchD = 1'b0; JumpALRD = 1'b0;
    ALUSrcD = 1'b0; ResultSrcD = RESULT_ALU; ImmSrcD = IMM_I; ALUControlD = ALU_ADD;
    case (InstrD[6:0])
      7'b0010011: begin RegWriteD = 1'b1; ALUSrcD = 1'b1; end
      7'b0110011: begin RegWriteD = 1'b1; ALUControlD = InstrD[30] ? ALU_SUB : ALU_ADD; end
      7'b0000011: begin RegWriteD = 1'b1; ALUSrcD = 1'b1; ResultSrcD = RESULT_MEM; end
      7'b0100011: begin MemWriteD = 1'b1; ALUSrcD = 1'b1; ImmSrcD = IMM_S; end
      7'b1100011: begin BranchD = 1'b1; ImmSrcD = IMM_B; ALUControlD = ALU_SUB; end
      7'b1101111: begin RegWriteD = 1'b1; JumpD = 1'b1; ImmSrcD = IMM_J; ResultSrcD = RESULT_PC4; end
      7'b1100111: begin
        RegWriteD = 1'b1; JumpD = 1'b1; JumpALRD = 1'b1; ALUSrcD = 1'b1; ResultSrcD = RESULT_PC4;
      end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (running && !reset) begin
      if (cyc < 64) fetch_pc[cyc] = PCF;
      if (MemWriteM) begin
        st_cyc.push_back(cyc);
        st_addr.push_back(ALUResultM);
        st_data.push_back(WriteDataM);
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_sw(int imm, int rs2, int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_beq(int imm, int rs2, int rs1);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(int imm, int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic load_nops();
    for (int i = 0; i < 128; i++) imem[i] = NOP_INSTR;
  endtask

  task automatic put(int addr, logic [31:0] instr);
    imem[addr / 4] = instr;
  endtask

  // Holds reset over two edges, then releases it mid-high-phase so the next negedge is cycle 0.
  task automatic start_program();
    reset = 1'b1;
    running = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    st_cyc.delete();
    st_addr.delete();
    st_data.delete();
    for (int i = 0; i < 64; i++) fetch_pc[i] = 32'h0;
    cyc = 0;
    running = 1'b1;
    reset = 1'b0;
  endtask

  task automatic run_cycles(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] want;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (PCF !== 32'h100) begin errors++; $display("[TB] FAIL reset_pcf got %h want %h", PCF, 32'h100); end
    checks++; if (MemWriteM !== 1'b0) begin errors++; $display("[TB] FAIL reset_memwrite got %b want 0", MemWriteM); end
    checks++; if (InstrD !== 32'h13) begin errors++; $display("[TB] FAIL reset_instrd got %h want 00000013", InstrD); end
    checks++; if (ALUResultM !== 32'h0) begin errors++; $display("[TB] FAIL reset_aluresult got %h want 0", ALUResultM); end
    checks++; if (WriteDataM !== 32'h0) begin errors++; $display("[TB] FAIL reset_writedata got %h want 0", WriteDataM); end
    checks++; if (Funct3M !== 3'b000) begin errors++; $display("[TB] FAIL reset_funct3 got %b want 000", Funct3M); end
    load_nops();
    start_program();
    run_cycles(4);
    for (int k = 0; k < 4; k++) begin
      want = 32'h100 + 32'(4 * k);
      checks++;
      if (fetch_pc[k] !== want) begin errors++; $display("[TB] FAIL reset_fetch%0d got %h want %h", k, fetch_pc[k], want); end
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] want;
    load_nops();
    put(32'h100, enc_i(5, 0, 0, 1, 7'b0010011));
    put(32'h104, enc_i(3, 1, 0, 2, 7'b0010011));
    put(32'h108, enc_r(0, 2, 1, 3));
    put(32'h10C, enc_sw(0, 3, 0));
    put(32'h110, enc_sw(4, 1, 0));
    put(32'h114, enc_sw(8, 2, 0));
    start_program();
    run_cycles(12);
    for (int k = 0; k < 8; k++) begin
      want = 32'h100 + 32'(4 * k);
      checks++;
      if (fetch_pc[k] !== want) begin errors++; $display("[TB] FAIL fwd_nostall%0d got %h want %h", k, fetch_pc[k], want); end
    end
    checks++;
    if (st_data.size() != 3) begin
      errors++; $display("[TB] FAIL fwd_store_count got %0d want 3", st_data.size());
    end else begin
      checks++; if (st_data[0] !== 32'd13) begin errors++; $display("[TB] FAIL fwd_x3 got %0d want 13", st_data[0]); end
      checks++; if (st_data[1] !== 32'd5) begin errors++; $display("[TB] FAIL fwd_x1 got %0d want 5", st_data[1]); end
      checks++; if (st_data[2] !== 32'd8) begin errors++; $display("[TB] FAIL fwd_x2 got %0d want 8", st_data[2]); end
      checks++; if (st_cyc[0] != 6) begin errors++; $display("[TB] FAIL fwd_store_cycle got %0d want 6", st_cyc[0]); end
      checks++; if (st_addr[2] !== 32'h8) begin errors++; $display("[TB] FAIL fwd_store_addr got %h want 8", st_addr[2]); end
    end
  endtask

  task automatic test_load_use();
    load_nops();
    put(32'h100, enc_i(0, 0, 3'b010, 4, 7'b0000011));
    put(32'h104, enc_r(0, 4, 4, 5));
    put(32'h108, enc_sw(16, 5, 0));
    start_program();
    run_cycles(12);
    checks++; if (fetch_pc[2] !== 32'h108) begin errors++; $display("[TB] FAIL lu_fetch2 got %h want 108", fetch_pc[2]); end
    checks++; if (fetch_pc[3] !== 32'h108) begin errors++; $display("[TB] FAIL lu_stall got %h want 108", fetch_pc[3]); end
    checks++; if (fetch_pc[4] !== 32'h10C) begin errors++; $display("[TB] FAIL lu_resume got %h want 10c", fetch_pc[4]); end
    checks++;
    if (st_data.size() != 1) begin
      errors++; $display("[TB] FAIL lu_store_count got %0d want 1", st_data.size());
    end else begin
      checks++; if (st_data[0] !== 32'd14) begin errors++; $display("[TB] FAIL lu_x5 got %0d want 14", st_data[0]); end
      checks++; if (st_addr[0] !== 32'h10) begin errors++; $display("[TB] FAIL lu_addr got %h want 10", st_addr[0]); end
      checks++; if (st_cyc[0] != 6) begin errors++; $display("[TB] FAIL lu_store_cycle got %0d want 6", st_cyc[0]); end
    end
  endtask

  task automatic test_branch();
    load_nops();
    put(32'h100, enc_i(1, 0, 0, 7, 7'b0010011));
    put(32'h104, enc_jal(-228, 0));
    put(32'h020, enc_beq(16, 0, 0));
    put(32'h024, enc_i(99, 0, 0, 7, 7'b0010011));
    put(32'h028, enc_sw(64, 0, 0));
    put(32'h030, enc_sw(68, 7, 0));
    start_program();
    run_cycles(14);
    checks++; if (fetch_pc[4] !== 32'h20) begin errors++; $display("[TB] FAIL br_jal_target got %h want 20", fetch_pc[4]); end
    checks++; if (fetch_pc[6] !== 32'h28) begin errors++; $display("[TB] FAIL br_shadow got %h want 28", fetch_pc[6]); end
    checks++; if (fetch_pc[7] !== 32'h30) begin errors++; $display("[TB] FAIL br_target got %h want 30", fetch_pc[7]); end
    checks++;
    if (st_data.size() != 1) begin
      errors++; $display("[TB] FAIL br_store_count got %0d want 1", st_data.size());
    end else begin
      checks++; if (st_addr[0] !== 32'h44) begin errors++; $display("[TB] FAIL br_addr got %h want 44", st_addr[0]); end
      checks++; if (st_data[0] !== 32'd1) begin errors++; $display("[TB] FAIL br_x7 got %0d want 1", st_data[0]); end
      checks++; if (st_cyc[0] != 10) begin errors++; $display("[TB] FAIL br_store_cycle got %0d want 10", st_cyc[0]); end
    end
  endtask

  task automatic test_jalr();
    load_nops();
    put(32'h100, enc_i(32'h41, 0, 0, 6, 7'b0010011));
    put(32'h104, enc_i(7, 0, 0, 9, 7'b0010011));
    put(32'h108, enc_i(8, 6, 0, 1, 7'b1100111));
    put(32'h10C, enc_i(1, 0, 0, 9, 7'b0010011));
    put(32'h110, enc_i(2, 0, 0, 9, 7'b0010011));
    put(32'h048, enc_sw(80, 1, 0));
    put(32'h04C, enc_sw(84, 9, 0));
    start_program();
    run_cycles(12);
    checks++; if (fetch_pc[5] !== 32'h48) begin errors++; $display("[TB] FAIL jalr_target got %h want 48", fetch_pc[5]); end
    checks++;
    if (st_data.size() != 2) begin
      errors++; $display("[TB] FAIL jalr_store_count got %0d want 2", st_data.size());
    end else begin
      checks++; if (st_data[0] !== 32'h10C) begin errors++; $display("[TB] FAIL jalr_link got %h want 10c", st_data[0]); end
      checks++; if (st_addr[0] !== 32'h50) begin errors++; $display("[TB] FAIL jalr_addr got %h want 50", st_addr[0]); end
      checks++; if (st_data[1] !== 32'd7) begin errors++; $display("[TB] FAIL jalr_x9 got %0d want 7", st_data[1]); end
      checks++; if (st_cyc[0] != 8) begin errors++; $display("[TB] FAIL jalr_store_cycle got %0d want 8", st_cyc[0]); end
    end
  endtask

  task automatic test_reset_mid_store();
    load_nops();
    put(32'h100, enc_i(32'h55, 0, 0, 8, 7'b0010011));
    put(32'h10C, enc_sw(96, 8, 0));
    start_program();
    run_cycles(6);
    reset = 1'b1;
    #1;
    checks++; if (PCF !== 32'h100) begin errors++; $display("[TB] FAIL midrst_pcf got %h want 100", PCF); end
    checks++; if (MemWriteM !== 1'b0) begin errors++; $display("[TB] FAIL midrst_memwrite_now got %b want 0", MemWriteM); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (MemWriteM !== 1'b0) begin errors++; $display("[TB] FAIL midrst_memwrite%0d got %b want 0", k, MemWriteM); end
    end
    checks++; if (st_data.size() != 0) begin errors++; $display("[TB] FAIL midrst_no_store got %0d want 0", st_data.size()); end
    start_program();
    run_cycles(10);
    checks++; if (fetch_pc[0] !== 32'h100) begin errors++; $display("[TB] FAIL midrst_restart got %h want 100", fetch_pc[0]); end
    checks++; if (fetch_pc[1] !== 32'h104) begin errors++; $display("[TB] FAIL midrst_next got %h want 104", fetch_pc[1]); end
    checks++;
    if (st_data.size() != 1) begin
      errors++; $display("[TB] FAIL midrst_rerun_count got %0d want 1", st_data.size());
    end else begin
      checks++; if (st_data[0] !== 32'h55) begin errors++; $display("[TB] FAIL midrst_rerun_data got %h want 55", st_data[0]); end
      checks++; if (st_cyc[0] != 6) begin errors++; $display("[TB] FAIL midrst_rerun_cycle got %0d want 6", st_cyc[0]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    running = 1'b0;
    cyc = 0;
    load_nops();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_jalr();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_datapath.md
# pipelined_datapath

Five-stage (F/D/E/M/W) RV32I-style datapath: the pipelined successor to the single-cycle datapath, parametrised in data width and reset vector. Owns PC, pipeline registers, register file, immediate extension, ALU, result selection and an internal hazard unit (forwarding, load-use stall, branch/jump flush). Sits between instruction/data memories and the combinational main decoder, which decodes `InstrD` and returns D-stage control.

## Interface
Parameters:
- `XLEN`, 32, datapath width; 32 or 64; immediates sign-extended to XLEN.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `PCF` out XLEN: instruction fetch address.
- `InstrF` in 32: instruction at `PCF`, same cycle.
- `InstrD` out 32: D-stage instruction, to decoder.
- `RegWriteD, MemWriteD, JumpD, BranchD, JumpALRD, ALUSrcD` in 1 each: decoder controls.
- `ResultSrcD` in 2: 00 ALU, 01 load data, 10 PC+4.
- `ImmSrcD` in 2, `ALUControlD` in 4: as the extend unit and ALU define.
- `ALUResultM` out XLEN: data address.
- `WriteDataM` out XLEN: store data.
- `MemWriteM` out 1; `Funct3M` out 3: store size.
- `ReadDataM` in XLEN: load data, valid same cycle as `ALUResultM`.

## Operation
- F: `PCF` register; next PC = `PCTargetE` if `PCSrcE`, else `PCF+4`.
- D: regfile reads rs1=`InstrD[19:15]`, rs2=`InstrD[24:20]`; W-stage write with internal bypass (RegWriteW, rdW≠0, rdW==rs → read `ResultW`); immediate extension.
- E: forwarding muxes on SrcA and WriteData (pre-ALUSrc mux); ALU; `PCTargetE` = `ALUResultE` if `JumpALRE` else `PCE+ImmExtE`; `PCSrcE` = `JumpE` | (`BranchE` & cond), cond from `Funct3E`: 000 Zero, 001 !Zero, 100 LessThan, 101 !LessThan, 110 LessThanUnsigned, 111 !LessThanUnsigned; other encodings not-taken.
- M: memory interface; load result passes to W.
- W: load data size/sign-selected by `Funct3W` via dmemselect; `ResultW` by `ResultSrcW`.
- Forwarding per E source: rsE==rdM, RegWriteM, rdM≠0 → `ALUResultM`; else rsE==rdW, RegWriteW, rdW≠0 → `ResultW`; else regfile value. M beats W. x0 never forwarded.
- Load-use: `ResultSrcE`==01, rdE≠0, rdE∈{rs1D, rs2D} → stall F and D one cycle, flush E. Applies even if the D instruction does not use rs2 (conservative; accepted).
- Control hazard: `PCSrcE`=1 → flush D and E next edge; PC loads target.
- Flush = load bubble: all control bits 0, rd=0, instruction field = 0x00000013 (nop).

## Timing
- Reset: `PCF`=RESET_PC; `InstrD`=0x00000013; every pipeline control bit 0; `ALUResultM`, `WriteDataM`=0; `MemWriteM`=0; `Funct3M`=0. Regfile contents not reset.
- First fetch from RESET_PC in the first cycle after reset deasserts. Reset mid-operation discards all in-flight instructions immediately, with no memory write that cycle.
- Latency: instruction fetched in cycle n writes back at edge ending cycle n+4; throughput 1/cycle absent hazards.
- Load-use penalty 1 cycle; taken branch/jump penalty 2 cycles.
- Load-use stall and redirect cannot coexist (E holds one instruction). Redirect beats any F/D stall by rule.
- Stalled registers hold value; flushed registers take bubble; D stall + E flush in the same cycle is legal.

## Structure
- `pipeline_pkg`: stage-register structs `if_id_t`, `id_ex_t`, `ex_mem_t`, `mem_wb_t`; `RESULT_ALU/MEM/PC4` constants; forward-select enum `FWD_RF/FWD_W/FWD_M`; `NOP_INSTR`.
- Sub-module `hazard_unit`: combinational forward selects plus stall/flush outputs. Existing regfile, extend, alu, adder, mux, dmemselect reused, widened to XLEN.

## Test plan
- Reset with RESET_PC=0x100 → `PCF`=0x100, `MemWriteM`=0; next three fetches at 0x104, 0x108, 0x10C.
- `addi x1,x0,5; addi x2,x1,3; add x3,x1,x2` → x3=13, zero stalls (M and W forwarding).
- `lw x4,0(x0)` with `ReadDataM`=0x7; then `add x5,x4,x4` → exactly one stall cycle; x5=14.
- `beq x0,x0,+16` at 0x20 → next fetch 0x30; two following instructions never write regfile or memory.
- `jalr x1,8(x6)` with x6=0x41 → PC=0x48 (bit0 cleared), x1=return PC+4.
- Assert reset while `sw` is in E → `MemWriteM` stays 0; PC restarts at RESET_PC.
